// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: load-use and branch interlocks, iterative-divide
// sequencer, and a saturating stall-cycle performance counter.
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rsD,
    input  logic [4:0]  rtD,
    input  logic [4:0]  writeRegAddrE,
    input  logic [4:0]  writeRegAddrM,
    input  logic        Regfile_weE,
    input  logic        Regfile_weM,
    input  logic        memtoRegE,
    input  logic        memtoRegM,
    input  logic        branchD,
    input  logic        divStartE,
    output logic        stallF,
    output logic        stallD,
    output logic        stallE,
    output logic        flushE,
    output logic        flushM,
    output logic        div_busy,
    output logic        hilo_we,
    output logic [15:0] stall_cycles
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [4:0]  div_cnt_q, div_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic match_e, match_m;
    logic lwstall, branchstall, divstall, any_stall;

    // Register 0 is hardwired, so a zero destination never conflicts.
    assign match_e = (writeRegAddrE != 5'd0) &&
                     ((writeRegAddrE == rsD) || (writeRegAddrE == rtD));
    assign match_m = (writeRegAddrM != 5'd0) &&
                     ((writeRegAddrM == rsD) || (writeRegAddrM == rtD));

    assign lwstall     = memtoRegE && Regfile_weE && match_e;
    assign branchstall = branchD &&
                         ((Regfile_weE && match_e) ||
                          (memtoRegM && Regfile_weM && match_m));

    assign divstall  = ((state_q == IDLE) && divStartE) || (state_q == BUSY);
    assign any_stall = lwstall || branchstall || divstall;

    assign stallF   = any_stall;
    assign stallD   = any_stall;
    assign stallE   = divstall;
    // EX is held during a divide, so it must not also be bubbled.
    assign flushE   = (lwstall || branchstall) && !divstall;
    assign flushM   = divstall;
    assign div_busy = (state_q == BUSY);
    assign hilo_we  = (state_q == DONE);

    assign stall_cycles = stall_cnt_q;

    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        case (state_q)
            IDLE: begin
                if (divStartE) begin
                    state_d   = BUSY;
                    div_cnt_d = 5'd31;
                end
            end
            BUSY: begin
                if (div_cnt_q == 5'd0) begin
                    state_d = DONE;
                end else begin
                    div_cnt_d = div_cnt_q - 5'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                div_cnt_d = 5'd0;
            end
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (any_stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            div_cnt_q   <= 5'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl.
// Outputs are checked 1 time unit after the rising edge.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rsD, rtD, writeRegAddrE, writeRegAddrM;
    logic        Regfile_weE, Regfile_weM, memtoRegE, memtoRegM;
    logic        branchD, divStartE;
    logic        stallF, stallD, stallE, flushE, flushM;
    logic        div_busy, hilo_we;
    logic [15:0] stall_cycles;

    int n_cmp = 0;
    int n_bad = 0;

    // {stallF, stallD, stallE, flushE, flushM, div_busy, hilo_we}
    logic [6:0] outs;
    assign outs = {stallF, stallD, stallE, flushE, flushM, div_busy, hilo_we};

    localparam logic [6:0] O_NONE = 7'b0000000;
    localparam logic [6:0] O_HAZ  = 7'b1101000;
    localparam logic [6:0] O_DIV0 = 7'b1110100;
    localparam logic [6:0] O_BUSY = 7'b1110110;
    localparam logic [6:0] O_DONE = 7'b0000001;

    hazard_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .rsD           (rsD),
        .rtD           (rtD),
        .writeRegAddrE (writeRegAddrE),
        .writeRegAddrM (writeRegAddrM),
        .Regfile_weE   (Regfile_weE),
        .Regfile_weM   (Regfile_weM),
        .memtoRegE     (memtoRegE),
        .memtoRegM     (memtoRegM),
        .branchD       (branchD),
        .divStartE     (divStartE),
        .stallF        (stallF),
        .stallD        (stallD),
        .stallE        (stallE),
        .flushE        (flushE),
        .flushM        (flushM),
        .div_busy      (div_busy),
        .hilo_we       (hilo_we),
        .stall_cycles  (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        rsD = 0; rtD = 0; writeRegAddrE = 0; writeRegAddrM = 0;
        Regfile_weE = 0; Regfile_weM = 0; memtoRegE = 0; memtoRegM = 0;
        branchD = 0; divStartE = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic set_lu();
        memtoRegE = 1; Regfile_weE = 1; writeRegAddrE = 5; rsD = 5;
    endtask

    initial begin
        bit saw_hilo;
        clr();
        do_reset();
        chk("reset_outs", 32'(outs), 32'(O_NONE));
        chk("reset_cnt", 32'(stall_cycles), 32'd0);

        // load-use on rs
        set_lu(); #1;
        chk("lu_rs", 32'(outs), 32'(O_HAZ));
        step(); clr(); #1;
        chk("lu_cnt", 32'(stall_cycles), 32'd1);

        // zero register never hazards
        memtoRegE = 1; Regfile_weE = 1; writeRegAddrE = 0; rsD = 0; #1;
        chk("zero_reg", 32'(outs), 32'(O_NONE));
        step(); clr(); #1;
        chk("zero_cnt", 32'(stall_cycles), 32'd1);

        // load-use on rt
        memtoRegE = 1; Regfile_weE = 1; writeRegAddrE = 7; rtD = 7; #1;
        chk("lu_rt", 32'(outs), 32'(O_HAZ));
        step(); clr(); #1;

        // EX-producer ALU result without a load: no stall outside branch
        Regfile_weE = 1; writeRegAddrE = 9; rtD = 9; #1;
        chk("alu_nobr", 32'(outs), 32'(O_NONE));
        branchD = 1; #1;
        chk("br_ex", 32'(outs), 32'(O_HAZ));
        step(); clr(); #1;

        branchD = 1; rtD = 9;
        memtoRegM = 1; Regfile_weM = 1; writeRegAddrM = 9; #1;
        chk("br_mem", 32'(outs), 32'(O_HAZ));
        memtoRegM = 0; #1;
        chk("br_mem_noload", 32'(outs), 32'(O_NONE));
        step(); clr(); #1;

        branchD = 1; Regfile_weE = 0; writeRegAddrE = 9; rtD = 9; #1;
        chk("br_ex_nowe", 32'(outs), 32'(O_NONE));
        clr(); #1;
        chk("cnt_after_haz", 32'(stall_cycles), 32'd3);

        // single-cycle divide start
        do_reset();
        chk("rst2_cnt", 32'(stall_cycles), 32'd0);
        divStartE = 1; #1;
        chk("div_idle", 32'(outs), 32'(O_DIV0));
        step(); divStartE = 0; #1;
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("div_busy%0d", i), 32'(outs), 32'(O_BUSY));
            step();
        end
        chk("div_done", 32'(outs), 32'(O_DONE));
        chk("div_cnt33", 32'(stall_cycles), 32'd33);
        step();
        chk("div_idle_after", 32'(outs), 32'(O_NONE));
        chk("div_cnt_hold", 32'(stall_cycles), 32'd33);

        // divStartE held high through BUSY/DONE must not reload
        do_reset();
        divStartE = 1;
        step();
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("hold_busy%0d", i), 32'(outs), 32'(O_BUSY));
            step();
        end
        chk("hold_done", 32'(outs), 32'(O_DONE));
        divStartE = 0;
        step();
        chk("hold_idle", 32'(outs), 32'(O_NONE));

        // load-use coinciding with divide start, then reset mid-divide
        do_reset();
        set_lu(); divStartE = 1; #1;
        chk("lu_div", 32'(outs), 32'(O_DIV0));
        step(); clr(); #1;
        for (int i = 0; i < 10; i++) step();
        chk("pre_abort", 32'(outs), 32'(O_BUSY));
        rst = 1; step(); rst = 0; #1;
        chk("abort_outs", 32'(outs), 32'(O_NONE));
        chk("abort_cnt", 32'(stall_cycles), 32'd0);
        saw_hilo = 0;
        for (int i = 0; i < 40; i++) begin
            if (hilo_we || div_busy) saw_hilo = 1;
            step();
        end
        chk("abort_no_hilo", 32'(saw_hilo), 32'd0);

        // reset wins over divStartE in the same cycle
        rst = 1; divStartE = 1; step();
        divStartE = 0; rst = 0; #1;
        chk("rst_prio_outs", 32'(outs), 32'(O_NONE));
        chk("rst_prio_cnt", 32'(stall_cycles), 32'd0);

        // saturation
        set_lu(); #1;
        for (int i = 0; i < 65534; i++) step();
        chk("sat_fffe", 32'(stall_cycles), 32'h0000FFFE);
        step();
        chk("sat_ffff", 32'(stall_cycles), 32'h0000FFFF);
        for (int i = 0; i < 5; i++) step();
        chk("sat_stable", 32'(stall_cycles), 32'h0000FFFF);
        clr();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL use one clock and a reset that is synchronous and active-high: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-002 The block SHALL have these pipeline inputs:
- rsD, rtD, input, 5 bits: ID-stage source register addresses.
- writeRegAddrE, writeRegAddrM, input, 5 bits: EX and MEM destination addresses.
- Regfile_weE, Regfile_weM, input, 1 bit: EX and MEM register-write enables.
- memtoRegE, memtoRegM, input, 1 bit: EX and MEM instruction is a load.
- branchD, input, 1 bit: ID instruction is a branch resolved in ID.
- divStartE, input, 1 bit: EX instruction is div or divu.
REQ-003 The block SHALL have these outputs:
- stallF, stallD, stallE, output, 1 bit: hold the PC, IF/ID and ID/EX registers.
- flushE, output, 1 bit: insert a bubble into ID/EX.
- flushM, output, 1 bit: insert a bubble into EX/MEM.
- div_busy, output, 1 bit: the divider sequence is active.
- hilo_we, output, 1 bit: one-cycle HI/LO write strobe.
- stall_cycles, output, 16 bits: performance count of stalled cycles.

Function
REQ-004 A register address of 0 SHALL never produce a hazard.
REQ-005 lwstall SHALL be 1 when all of these hold: memtoRegE=1, Regfile_weE=1, writeRegAddrE!=0, and writeRegAddrE equals rsD or rtD.
REQ-006 branchstall SHALL be 1 when branchD=1 and either of these holds:
- Regfile_weE=1, writeRegAddrE!=0, and writeRegAddrE equals rsD or rtD.
- memtoRegM=1, Regfile_weM=1, writeRegAddrM!=0, and writeRegAddrM equals rsD or rtD.
REQ-007 The divider FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-008 The FSM SHALL use a 5-bit down-counter, div_cnt.
REQ-009 In IDLE with divStartE=1, the FSM SHALL move to BUSY on the next edge and load div_cnt=31.
REQ-010 In BUSY, div_cnt SHALL decrement each cycle; when div_cnt=0 the FSM SHALL move to DONE, so BUSY lasts exactly 32 cycles.
REQ-011 DONE SHALL last one cycle and then return to IDLE unconditionally.
REQ-012 divstall SHALL be 1 in IDLE while divStartE=1, and in every BUSY cycle.
REQ-013 divstall SHALL be 0 in DONE, so the div instruction advances out of EX in the DONE cycle.
REQ-014 divStartE SHALL be ignored in BUSY and DONE, with no restart and no counter reload.
REQ-015 div_busy SHALL be 1 exactly when the state is BUSY.
REQ-016 hilo_we SHALL be 1 exactly when the state is DONE.
REQ-017 stallF and stallD SHALL equal lwstall OR branchstall OR divstall.
REQ-018 stallE SHALL equal divstall.
REQ-019 flushE SHALL equal (lwstall OR branchstall) AND NOT divstall; divstall takes priority because EX holds its instruction.
REQ-020 flushM SHALL equal divstall, so MEM receives bubbles while EX is held.
REQ-021 All stall and flush outputs SHALL be combinational from the inputs and the FSM state, with zero-cycle latency.
REQ-022 stall_cycles SHALL increment by 1 on each edge where stallF=1.
REQ-023 stall_cycles SHALL saturate at 16'hFFFF and SHALL NOT wrap.
REQ-024 When lwstall and divstall occur in the same cycle, the outputs SHALL be stallF/D/E=1, flushE=0 and flushM=1.

Reset
REQ-025 While rst=1 at a clock edge, the state SHALL become IDLE, div_cnt SHALL become 0 and stall_cycles SHALL become 0.
REQ-026 After reset, div_busy=0 and hilo_we=0.
REQ-027 After reset with all inputs 0, all stall and flush outputs SHALL be 0.
REQ-028 rst during BUSY or DONE SHALL abort the sequence: IDLE on the next edge, with no hilo_we pulse.
REQ-029 rst SHALL take priority over divStartE and over stall counting in the same cycle.

Verification
REQ-030 Load-use: memtoRegE=1, Regfile_weE=1, writeRegAddrE=5, rsD=5 -> stallF=stallD=1, flushE=1, stallE=0, flushM=0; stall_cycles increments by 1.
REQ-031 Zero register: the REQ-030 stimulus with writeRegAddrE=0 and rsD=0 -> all stall and flush outputs 0.
REQ-032 Branch hazard: branchD=1, rtD=9 with either of these producers -> stallF=stallD=flushE=1:
- Regfile_weE=1, writeRegAddrE=9.
- memtoRegM=1, Regfile_weM=1, writeRegAddrM=9.
With memtoRegM=0 and a MEM match only -> no stall.
REQ-033 Divide: divStartE=1 for one cycle in IDLE -> stallF/D/E=1 and flushM=1 for 33 consecutive cycles; div_busy=1 for 32 of them; then one cycle with hilo_we=1 and no stall; then IDLE; stall_cycles=33.
REQ-034 Reset mid-divide: assert rst at BUSY cycle 10 -> IDLE next edge, all outputs 0, stall_cycles=0, no hilo_we pulse.
REQ-035 Saturation: hold lwstall for 65,540 cycles -> stall_cycles=16'hFFFF and stable.
